// File: rtl/frame_rx_if.sv
// Bus bundle between the serial frame receiver and its consumer:
// the single serial line in, and the checked byte pair plus status strobes out.
interface frame_rx_if;
  logic       rx_line;
  logic [7:0] rx_data;
  logic [7:0] rx_crc;
  logic       rx_valid;
  logic       rx_crc_ok;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    input  rx_line,
    output rx_data,
    output rx_crc,
    output rx_valid,
    output rx_crc_ok,
    output rx_frame_err,
    output rx_busy
  );

  modport slave (
    output rx_line,
    input  rx_data,
    input  rx_crc,
    input  rx_valid,
    input  rx_crc_ok,
    input  rx_frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/frame_rx.sv
// Serial frame receiver: start, 8 data bits, 8 check bits (LSB first), stop.
// The recovered pair is checked against KEY and handed on with a one-cycle strobe.
module frame_rx #(
  parameter logic [7:0] KEY          = 8'b00110111,
  parameter int         CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  frame_rx_if.master  bus
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CRC   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BREAK = 3'd5;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_sync_d;
  logic              w_sync;
  logic              w_fall;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit;
  logic              w_tick_half;
  logic              w_tick_full;
  logic              w_shift_data;
  logic              w_shift_crc;

  logic [DATA_W-1:0] r_data_sh;
  logic [DATA_W-1:0] r_crc_sh;
  logic              w_crc_ok;

  logic [DATA_W-1:0] r_rx_data;
  logic [DATA_W-1:0] r_rx_crc;
  logic              r_rx_crc_ok;
  logic              r_rx_valid;
  logic              r_rx_frame_err;
  logic              r_rx_busy;

  // Stage: line synchronizer and falling-edge detect (idle level is high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= bus.rx_line;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_sync      = r_sync2;
  assign w_fall      = r_sync_d & ~r_sync2;
  assign w_tick_half = (r_cnt == C_HALF);
  assign w_tick_full = (r_cnt == C_FULL);

  assign w_shift_data = (r_state == S_DATA) && w_tick_full;
  assign w_shift_crc  = (r_state == S_CRC)  && w_tick_full;

  // Stage: bit-sampling FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_bit          <= '0;
      r_rx_data      <= '0;
      r_rx_crc       <= '0;
      r_rx_crc_ok    <= 1'b0;
      r_rx_valid     <= 1'b0;
      r_rx_frame_err <= 1'b0;
      r_rx_busy      <= 1'b0;
    end else begin
      r_rx_valid     <= 1'b0;
      r_rx_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (w_tick_half) begin
            r_cnt <= '0;
            if (!w_sync) begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA, S_CRC: begin
          if (w_tick_full) begin
            r_cnt <= '0;
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state <= (r_state == S_DATA) ? S_CRC : S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_tick_full) begin
            r_cnt <= '0;
            if (w_sync) begin
              r_rx_data   <= r_data_sh;
              r_rx_crc    <= r_crc_sh;
              r_rx_crc_ok <= w_crc_ok;
              r_rx_valid  <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_rx_frame_err <= 1'b1;
              r_state        <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          // A held-low line after a bad stop is a break, never a new start.
          if (w_sync) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
      r_rx_busy <= 1'b0;
      if (r_state != S_IDLE) begin
        r_rx_busy <= 1'b1;
      end
    end
  end

  // Stage: data shift registers (no reset; contents only matter once a frame completes)
  always_ff @(posedge clk) begin
    if (w_shift_data) begin
      r_data_sh <= {w_sync, r_data_sh[DATA_W-1:1]};
    end
    if (w_shift_crc) begin
      r_crc_sh <= {w_sync, r_crc_sh[DATA_W-1:1]};
    end
  end

  frame_rx_checksum #(
    .DATA_W (DATA_W),
    .KEY    (KEY)
  ) u_checksum (
    .i_data (r_data_sh),
    .i_crc  (r_crc_sh),
    .o_ok   (w_crc_ok)
  );

  // Stage: outputs
  assign bus.rx_data      = r_rx_data;
  assign bus.rx_crc       = r_rx_crc;
  assign bus.rx_crc_ok    = r_rx_crc_ok;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.rx_frame_err = r_rx_frame_err;
  assign bus.rx_busy      = (r_state != S_IDLE);

  logic w_unused;
  assign w_unused = r_rx_busy;

endmodule

// Check byte is the data byte XORed with the key.
module frame_rx_checksum #(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] KEY    = '0
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_crc,
  output logic              o_ok
);
  assign o_ok = (i_crc == (i_data ^ KEY));
endmodule

// File: tb/tb_frame_rx.sv
// Directed bench for frame_rx: serial frames driven bit by bit at CLKS_PER_BIT=4.
module tb_frame_rx;
  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;

  logic clk;
  logic rst_n;
  frame_rx_if bus ();

  frame_rx #(.KEY(8'b00110111), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_busy = 0;
  int n_overlap = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  logic last_ok = 1'b0;
  logic prev_ok = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_valid = n_valid + 1;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      prev_ok = last_ok;
      last_ok = bus.rx_crc_ok;
    end
    if (bus.rx_frame_err) n_ferr = n_ferr + 1;
    if (bus.rx_busy) n_busy = n_busy + 1;
    if (bus.rx_valid && bus.rx_frame_err) n_overlap = n_overlap + 1;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.rx_line = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [7:0] c, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    bus.rx_line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int v0, f0, b0, t0;
  logic [7:0] af;

  initial begin
    bus.rx_line = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", bus.rx_data, 8'h00);
    check("rst_crc", bus.rx_crc, 8'h00);
    check("rst_ok", bus.rx_crc_ok, 1'b0);
    check("rst_valid", bus.rx_valid, 1'b0);
    check("rst_ferr", bus.rx_frame_err, 1'b0);
    check("rst_busy", bus.rx_busy, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // T1
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hAA, 8'h9D, 1'b1);
    idle(6);
    check("t1_nvalid", n_valid - v0, 1);
    check("t1_data", bus.rx_data, 8'hAA);
    check("t1_crc", bus.rx_crc, 8'h9D);
    check("t1_ok", bus.rx_crc_ok, 1'b1);
    check("t1_nferr", n_ferr - f0, 0);
    check("t1_busy", bus.rx_busy, 1'b0);

    // T2
    send_frame(8'hAD, 8'h9B, 1'b1);
    idle(6);
    check("t2_data", bus.rx_data, 8'hAD);
    check("t2_crc", bus.rx_crc, 8'h9B);
    check("t2_ok_bad", bus.rx_crc_ok, 1'b0);
    send_frame(8'hAF, 8'h98, 1'b1);
    idle(6);
    check("t2_data2", bus.rx_data, 8'hAF);
    check("t2_ok_good", bus.rx_crc_ok, 1'b1);

    // T3: one-clock glitch
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    bus.rx_line = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_line = 1'b1;
    repeat (HALF + 2) @(posedge clk);
    #1;
    check("t3_busy_seen", (n_busy > b0) ? 1 : 0, 1);
    check("t3_busy_clear", bus.rx_busy, 1'b0);
    check("t3_nvalid", n_valid - v0, 0);
    check("t3_nferr", n_ferr - f0, 0);
    idle(8);

    // T4: bad stop bit, long break, then a good frame
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hAA, 8'h9D, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("t4_nferr", n_ferr - f0, 1);
    check("t4_nvalid_err", n_valid - v0, 0);
    check("t4_data_held", bus.rx_data, 8'hAF);
    idle(8);
    check("t4_busy_after_break", bus.rx_busy, 1'b0);
    send_frame(8'hAD, 8'h9A, 1'b1);
    idle(6);
    check("t4_nvalid", n_valid - v0, 1);
    check("t4_data", bus.rx_data, 8'hAD);
    check("t4_ok", bus.rx_crc_ok, 1'b1);
    check("t4_nferr_total", n_ferr - f0, 1);

    // T5: reset during data bit 5
    af = 8'hAF;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(af[i]);
    bus.rx_line = af[5];
    repeat (HALF) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("t5_rst_data", bus.rx_data, 8'h00);
    check("t5_rst_crc", bus.rx_crc, 8'h00);
    check("t5_rst_ok", bus.rx_crc_ok, 1'b0);
    check("t5_rst_valid", bus.rx_valid, 1'b0);
    check("t5_rst_busy", bus.rx_busy, 1'b0);
    bus.rx_line = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    rst_n = 1'b1;
    idle(4);
    v0 = n_valid;
    send_frame(8'hAF, 8'h98, 1'b1);
    idle(6);
    check("t5_nvalid", n_valid - v0, 1);
    check("t5_data", bus.rx_data, 8'hAF);
    check("t5_ok", bus.rx_crc_ok, 1'b1);

    // T6: zero-gap back-to-back frames
    v0 = n_valid;
    send_frame(8'hAA, 8'h9D, 1'b1);
    send_frame(8'hAD, 8'h9A, 1'b1);
    idle(8);
    check("t6_nvalid", n_valid - v0, 2);
    t0 = last_valid_cyc - prev_valid_cyc;
    check("t6_spacing", t0, 18 * CPB);
    check("t6_ok_first", prev_ok, 1'b1);
    check("t6_ok_second", last_ok, 1'b1);
    check("t6_data", bus.rx_data, 8'hAD);
    check("t6_crc", bus.rx_crc, 8'h9A);

    check("no_overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
